// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit
//   Per-register scoreboard for the ID stage. Each architectural register has a
//   small down-counter holding the cycles left until its pending result can be
//   forwarded. The ID instruction is held (PC / IF-ID frozen, bubble into ID/EX)
//   while any source it reads is still pending (RAW) or while its own result
//   would overtake an older pending write to the same register (WAW).
//
// Optional feature:
//   HAZARD_PERF_CNT_EN  - when defined, stall_cycles counts hazard-stall edges
//                         (saturating); otherwise stall_cycles is tied to 0.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   id_valid          IF/ID holds a real instruction
//   id_rs, id_rt      source registers; id_use_rs / id_use_rt qualify them
//   id_rd             destination register; id_reg_write qualifies it
//   id_lat            producer latency (0 treated as 1, clamped to MAX_LAT)
//   flush             kill the ID instruction
//   ext_stall         whole-pipeline freeze
//   pc_load, ifid_ld  PC / IF-ID write enables
//   sel_signal        zero the control fields entering ID/EX
//   issue             ID instruction advances to EX this cycle
//   busy_any          some scoreboard entry is non-zero
//   stall_cycles      hazard-stall counter
module scoreboard_hazard_unit #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned MAX_LAT    = 4,
   localparam int unsigned LAT_W     = $clog2(MAX_LAT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic [LAT_W-1:0]      id_lat,
   input  logic                  flush,
   input  logic                  ext_stall,
   output logic                  pc_load,
   output logic                  ifid_ld,
   output logic                  sel_signal,
   output logic                  issue,
   output logic                  busy_any,
   output logic [31:0]           stall_cycles
);

   localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

   logic [LAT_W-1:0] cnt_q [NUM_REGS];
   logic [LAT_W-1:0] cnt_d [NUM_REGS];

   logic [LAT_W-1:0] lat_eff;
   logic [LAT_W-1:0] lat_m1;
   logic             raw;
   logic             waw;
   logic             hazard;

   // Effective producer latency: 0 means single-cycle, anything above MAX_LAT clamps.
   always_comb begin
      lat_eff = id_lat;
      if (id_lat == '0) begin
         lat_eff = LAT_W'(1);
      end else if (id_lat > LAT_W'(MAX_LAT)) begin
         lat_eff = LAT_W'(MAX_LAT);
      end
      lat_m1 = lat_eff - LAT_W'(1);
   end

   // Hazard detection; entry 0 always reads zero so r0 never stalls.
   always_comb begin
      raw    = 1'b0;
      waw    = 1'b0;
      hazard = 1'b0;
      if (id_valid) begin
         if (id_use_rs && (id_rs != '0) && (cnt_q[id_rs] != '0)) begin
            raw = 1'b1;
         end
         if (id_use_rt && (id_rt != '0) && (cnt_q[id_rt] != '0)) begin
            raw = 1'b1;
         end
         // A younger write must not land before an older pending one.
         if (id_reg_write && (id_rd != '0) && (cnt_q[id_rd] > lat_m1)) begin
            waw = 1'b1;
         end
      end
      hazard = (raw | waw) & ~flush;
   end

   // Pipeline control outputs.
   always_comb begin
      pc_load    = 1'b0;
      ifid_ld    = 1'b0;
      sel_signal = 1'b0;
      issue      = 1'b0;
      pc_load    = ~hazard & ~ext_stall;
      ifid_ld    = ~hazard & ~ext_stall;
      sel_signal = (hazard | flush) & ~ext_stall;
      issue      = id_valid & ~hazard & ~flush & ~ext_stall;
   end

   // Next scoreboard state: age every pending entry, then load the issuing producer.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
      end
      if (!ext_stall) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
         end
         if (issue && id_reg_write && (id_rd != '0)) begin
            cnt_d[id_rd] = lat_m1;
         end
      end
      cnt_d[0] = '0;
   end

   // Scoreboard state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   // Any pending result anywhere.
   always_comb begin
      busy_any = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (cnt_q[r] != '0) begin
            busy_any = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q;

   // Saturating count of edges spent in a hazard stall (freeze edges excluded).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= 32'd0;
      end else if (hazard && !ext_stall && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit. The reference model tracks,
// per register, the pipeline "epoch" (count of non-frozen edges) at which the
// pending result becomes forwardable; remaining cycles = ready - epoch.
module tb_scoreboard_hazard_unit;

   localparam int AW   = 5;
   localparam int LW   = 3;
   localparam int MAXL = 4;
   localparam int NR   = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic          id_use_rs, id_use_rt, id_reg_write;
   logic [LW-1:0] id_lat;
   logic          flush, ext_stall;
   logic          pc_load, ifid_ld, sel_signal, issue, busy_any;
   logic [31:0]   stall_cycles;

   scoreboard_hazard_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_lat(id_lat), .flush(flush),
      .ext_stall(ext_stall), .pc_load(pc_load), .ifid_ld(ifid_ld),
      .sel_signal(sel_signal), .issue(issue), .busy_any(busy_any),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   int          epoch;
   int          ready [NR];
   int unsigned stalls;
   int          checks;
   int          passed;

   // ---------------- reference model ----------------
   function automatic int eff_lat(input logic [LW-1:0] l);
      if (l == 0) return 1;
      if (int'(l) > MAXL) return MAXL;
      return int'(l);
   endfunction

   function automatic int rem(input int r);
      if (rst !== 1'b1 || r == 0) return 0;
      return (ready[r] > epoch) ? ready[r] - epoch : 0;
   endfunction

   function automatic bit m_hazard();
      bit raw, waw;
      raw = id_valid && ((id_use_rs && rem(int'(id_rs)) != 0) ||
                         (id_use_rt && rem(int'(id_rt)) != 0));
      waw = id_valid && id_reg_write && (rem(int'(id_rd)) > eff_lat(id_lat) - 1);
      return (raw || waw) && !flush;
   endfunction

   function automatic bit m_issue();
      return id_valid && !m_hazard() && !flush && !ext_stall;
   endfunction

   function automatic bit m_busy();
      for (int r = 0; r < NR; r++) if (rem(r) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_stall();
`ifdef HAZARD_PERF_CNT_EN
      return (rst === 1'b1) ? 32'(stalls) : 32'd0;
`else
      return 32'd0;
`endif
   endfunction

   // Advance one clock edge, updating the model from the inputs seen at the edge.
   task automatic tick();
      bit h, is;
      int l;
      @(posedge clk);
      h  = m_hazard();
      is = m_issue();
      l  = eff_lat(id_lat);
      if (rst !== 1'b1) begin
         for (int r = 0; r < NR; r++) ready[r] = epoch;
         stalls = 0;
      end else if (!ext_stall) begin
         if (h && stalls != 32'hFFFF_FFFF) stalls++;
         epoch++;
         if (is && id_reg_write && id_rd != 0) ready[int'(id_rd)] = epoch + l - 1;
      end
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
      id_reg_write = 0; id_lat = 0; flush = 0; ext_stall = 0;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i <= MAXL; i++) tick();
   endtask

   task automatic producer(input int rd, input int lat);
      idle();
      id_valid = 1; id_reg_write = 1; id_rd = AW'(rd); id_lat = LW'(lat);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      rst = 0;
      #2;
      checks++; if (pc_load !== 1'b1) $display("FAIL reset_pc_load got %b want 1", pc_load); else passed++;
      checks++; if (busy_any !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_any); else passed++;
      checks++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cycles); else passed++;
      flush = 1; #1;
      checks++; if (sel_signal !== 1'b1) $display("FAIL reset_flush_sel got %b want 1", sel_signal); else passed++;
      ext_stall = 1; #1;
      checks++; if (sel_signal !== 1'b0 || pc_load !== 1'b0)
         $display("FAIL reset_ext_stall got sel=%b pc=%b want 0 0", sel_signal, pc_load); else passed++;
      idle();
      tick(); tick();
      rst = 1;
      id_valid = 1; id_rs = 3; id_use_rs = 1;
      #2;
      checks++; if (pc_load !== 1'b1) $display("FAIL post_reset_pc_load got %b want 1", pc_load); else passed++;
      checks++; if (sel_signal !== 1'b0) $display("FAIL post_reset_sel got %b want 0", sel_signal); else passed++;
      checks++; if (issue !== 1'b1) $display("FAIL post_reset_issue got %b want 1", issue); else passed++;
      checks++; if (busy_any !== 1'b0) $display("FAIL post_reset_busy got %b want 0", busy_any); else passed++;
      checks++; if (stall_cycles !== 32'd0) $display("FAIL post_reset_stall_cnt got %0d want 0", stall_cycles); else passed++;
      tick();
   endtask

   task automatic test_load_use();
      int n; bit got;
      drain();
      producer(8, 2); #2;
      checks++; if (issue !== 1'b1) $display("FAIL load_use_producer_issue got %b want 1", issue); else passed++;
      tick();
      idle(); id_valid = 1; id_rs = 8; id_use_rs = 1;
      n = 0; got = 0;
      for (int k = 0; k < 10; k++) begin
         #2;
         if (issue === 1'b1) begin got = 1; break; end
         checks++; if (pc_load !== 1'b0 || ifid_ld !== 1'b0 || sel_signal !== 1'b1)
            $display("FAIL load_use_stall_ctrl got pc=%b ifid=%b sel=%b want 0 0 1", pc_load, ifid_ld, sel_signal); else passed++;
         n++; tick();
      end
      checks++; if (!got || n != 1) $display("FAIL load_use_stalls got %0d (issued=%b) want 1", n, got); else passed++;
      checks++; if (stall_cycles !== exp_stall()) $display("FAIL load_use_stall_cnt got %0d want %0d", stall_cycles, exp_stall()); else passed++;
      tick();
   endtask

   task automatic test_multiply();
      int n; bit got;
      drain();
      producer(9, 4); tick();
      idle(); id_valid = 1; id_rt = 9; id_use_rt = 1;
      n = 0; got = 0;
      for (int k = 0; k < 10; k++) begin
         #2;
         if (issue === 1'b1) begin got = 1; break; end
         checks++; if (busy_any !== 1'b1) $display("FAIL mul_busy_during_stall got %b want 1", busy_any); else passed++;
         n++; tick();
      end
      checks++; if (!got || n != 3) $display("FAIL mul_stalls got %0d (issued=%b) want 3", n, got); else passed++;
      checks++; if (busy_any !== 1'b0) $display("FAIL mul_busy_at_issue got %b want 0", busy_any); else passed++;
      tick();
   endtask

   task automatic test_ext_stall();
      int n; bit got;
      drain();
      producer(9, 4); tick();
      idle(); id_valid = 1; id_rs = 9; id_use_rs = 1; ext_stall = 1;
      for (int k = 0; k < 2; k++) begin
         #2;
         checks++; if (pc_load !== 1'b0 || sel_signal !== 1'b0 || issue !== 1'b0 || busy_any !== 1'b1)
            $display("FAIL freeze_ctrl got pc=%b sel=%b issue=%b busy=%b want 0 0 0 1",
                     pc_load, sel_signal, issue, busy_any); else passed++;
         tick();
      end
      ext_stall = 0;
      n = 0; got = 0;
      for (int k = 0; k < 10; k++) begin
         #2;
         if (issue === 1'b1) begin got = 1; break; end
         n++; tick();
      end
      // The held count of 3 shows up as exactly 3 hazard cycles after the freeze.
      checks++; if (!got || n + 2 != 5) $display("FAIL freeze_total_cycles got %0d (issued=%b) want 5", n + 2, got); else passed++;
      checks++; if (stall_cycles !== exp_stall()) $display("FAIL freeze_stall_cnt got %0d want %0d", stall_cycles, exp_stall()); else passed++;
      tick();
   endtask

   task automatic test_waw();
      int n; bit got;
      drain();
      producer(5, 4); tick();
      idle(); tick();                 // one unrelated cycle between the two writers
      producer(5, 1);
      n = 0; got = 0;
      for (int k = 0; k < 10; k++) begin
         #2;
         if (issue === 1'b1) begin got = 1; break; end
         n++; tick();
      end
      checks++; if (!got || n != 2) $display("FAIL waw_stalls got %0d (issued=%b) want 2", n, got); else passed++;
      tick();
      idle(); id_valid = 1; id_rs = 5; id_use_rs = 1; #2;
      checks++; if (busy_any !== 1'b0 || issue !== 1'b1)
         $display("FAIL waw_cnt_clear got busy=%b issue=%b want 0 1", busy_any, issue); else passed++;
      tick();
   endtask

   task automatic test_flush_zero();
      drain();
      producer(7, 4); tick();
      idle(); id_valid = 1; id_rs = 7; id_use_rs = 1;
      id_reg_write = 1; id_rd = 12; id_lat = 4; flush = 1; #2;
      checks++; if (sel_signal !== 1'b1 || pc_load !== 1'b1 || issue !== 1'b0)
         $display("FAIL flush_ctrl got sel=%b pc=%b issue=%b want 1 1 0", sel_signal, pc_load, issue); else passed++;
      tick();
      idle(); id_valid = 1; id_rs = 12; id_use_rs = 1; #2;
      checks++; if (issue !== 1'b1) $display("FAIL flush_no_update got issue=%b want 1", issue); else passed++;
      tick();
      drain();
      producer(0, 4); #2;
      checks++; if (issue !== 1'b1) $display("FAIL r0_issue got %b want 1", issue); else passed++;
      tick();
      idle(); #2;
      checks++; if (busy_any !== 1'b0) $display("FAIL r0_busy got %b want 0", busy_any); else passed++;
      tick();
   endtask

   task automatic test_reset_mid_stall();
      drain();
      producer(9, 4); tick();
      idle(); id_valid = 1; id_rs = 9; id_use_rs = 1; #2;
      checks++; if (pc_load !== 1'b0) $display("FAIL mid_reset_pre got pc=%b want 0", pc_load); else passed++;
      rst = 0; #1;
      checks++; if (pc_load !== 1'b1 || sel_signal !== 1'b0 || busy_any !== 1'b0 || issue !== 1'b1)
         $display("FAIL mid_reset_clear got pc=%b sel=%b busy=%b issue=%b want 1 0 0 1",
                  pc_load, sel_signal, busy_any, issue); else passed++;
      checks++; if (stall_cycles !== 32'd0) $display("FAIL mid_reset_stall_cnt got %0d want 0", stall_cycles); else passed++;
      tick();
      rst = 1; #2;
      checks++; if (issue !== 1'b1 || busy_any !== 1'b0)
         $display("FAIL mid_reset_release got issue=%b busy=%b want 1 0", issue, busy_any); else passed++;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst          = ($urandom_range(0, 49) != 0);
         id_valid     = ($urandom_range(0, 9) != 0);
         id_rs        = AW'($urandom_range(0, 3));
         id_rt        = AW'($urandom_range(0, 3));
         id_rd        = AW'($urandom_range(0, 3));
         id_use_rs    = ($urandom_range(0, 9) < 6);
         id_use_rt    = ($urandom_range(0, 9) < 6);
         id_reg_write = ($urandom_range(0, 9) < 7);
         id_lat       = LW'($urandom_range(0, 7));
         flush        = ($urandom_range(0, 9) == 0);
         ext_stall    = ($urandom_range(0, 4) == 0);
         #2;
         checks++; if (pc_load !== (!m_hazard() && !ext_stall))
            $display("FAIL rnd_pc_load cyc %0d got %b want %b", c, pc_load, !m_hazard() && !ext_stall); else passed++;
         checks++; if (ifid_ld !== (!m_hazard() && !ext_stall))
            $display("FAIL rnd_ifid_ld cyc %0d got %b want %b", c, ifid_ld, !m_hazard() && !ext_stall); else passed++;
         checks++; if (sel_signal !== ((m_hazard() || flush) && !ext_stall))
            $display("FAIL rnd_sel cyc %0d got %b want %b", c, sel_signal, (m_hazard() || flush) && !ext_stall); else passed++;
         checks++; if (issue !== m_issue())
            $display("FAIL rnd_issue cyc %0d got %b want %b", c, issue, m_issue()); else passed++;
         checks++; if (busy_any !== m_busy())
            $display("FAIL rnd_busy cyc %0d got %b want %b", c, busy_any, m_busy()); else passed++;
         checks++; if (stall_cycles !== exp_stall())
            $display("FAIL rnd_stall_cnt cyc %0d got %0d want %0d", c, stall_cycles, exp_stall()); else passed++;
         tick();
      end
      rst = 1;
      idle();
      tick();
   endtask

   initial begin
      checks = 0; passed = 0; epoch = 0; stalls = 0;
      for (int r = 0; r < NR; r++) ready[r] = 0;
      rst = 0;
      idle();
      @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_multiply();
      test_ext_stall();
      test_waw();
      test_flush_zero();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
